fetch_stage: RTL

//  PC register and instruction-fetch control. Sits directly upstream of the ID stage.

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage_chk.sv | 30 +++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   - FS_RESET_PC : first fetch address after reset
//   - fetch_state_e : BOOT / FETCH / HOLD controller states
//   - fetch_entry_t : {pc, inst} pair held by the skid slot
//   - align_pc()    : forces a fetch address onto a word boundary
package fetch_stage_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] FS_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word-sized, so the two low address bits are always zero
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM request bus between the fetch stage and the ROM.
//   rom_en    : fetch request valid (fetch -> ROM)
//   rom_addr  : fetch address, stable while rom_en=1 and rom_rdy=0 (fetch -> ROM)
//   rom_rdy   : rom_rdata valid for the current request (ROM -> fetch)
//   rom_rdata : fetched instruction word (ROM -> fetch)
interface fetch_stage_if;

    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_rdy;
    logic [31:0] rom_rdata;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_rdy,
        input  rom_rdata
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_rdy,
        output rom_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for one fetched {pc, inst} pair.
//   clk, rst_n : clock and asynchronous active-low reset (clears the entry)
//   load       : capture din; takes priority over unload
//   din        : {pc, inst} to capture
//   unload     : release the held entry
//   valid      : an entry is held
//   data       : the held {pc, inst}
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  fetch_entry_t din,
    input  logic         unload,
    output logic         valid,
    output fetch_entry_t data
);

    logic         valid_r;
    fetch_entry_t data_r;

    // Holding register: capture on load, drop on unload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (unload) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/fetch_stage_chk.sv
// Protocol checks for the fetch stage (simulation only, no logic).
//   branch_flag / pend_vld : a second redirect may not arrive while one is pending
//   rom_en / rom_rdy / rom_addr : an unanswered request stays asserted and stable
//   skid_unload / skid_valid : the skid slot is only replayed when it holds an entry
module fetch_stage_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        branch_flag,
    input logic        pend_vld,
    input logic        rom_en,
    input logic        rom_rdy,
    input logic [31:0] rom_addr,
    input logic        skid_unload,
    input logic        skid_valid
);

    a_no_double_branch: assert property (
        @(posedge clk) disable iff (!rst_n) !(branch_flag && pend_vld)
    );

    a_req_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (rom_en && !rom_rdy) |=> (rom_en && $stable(rom_addr))
    );

    a_unload_has_entry: assert property (
        @(posedge clk) disable iff (!rst_n) skid_unload |-> skid_valid
    );

endmodule

// File: rtl/fetch_stage.sv
// PC register and instruction-fetch control, directly upstream of ID.
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall           : IF/ID outputs must hold this cycle
//   branch_flag/addr: one-cycle redirect from ID (delay-slot semantics)
//   rom             : instruction-ROM request bus (master side)
//   if_valid/pc/inst: instruction presented to ID
// The word in flight when a redirect arrives is always delivered (delay slot);
// only the following fetch uses the target. A redirect that arrives when the
// pc cannot advance is parked in a pending register until the next advance.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FS_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_flag,
    input  logic [31:0]          branch_addr,
    fetch_stage_if.master        rom,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_inst
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  next_pc_s;
    logic         pend_vld_r;
    logic [31:0]  pend_addr_r;
    logic         rom_en_r;
    logic         if_valid_r;
    logic [31:0]  if_pc_r;
    logic [31:0]  if_inst_r;

    logic         adv_s;
    logic         take_rom_s;
    logic         bubble_s;
    logic         skid_load_s;
    logic         skid_unload_s;
    logic         skid_valid_s;
    fetch_entry_t skid_in_s;
    fetch_entry_t skid_data_s;

    // Controller: next state and per-cycle actions
    always_comb begin
        state_nxt_s   = state_r;
        adv_s         = 1'b0;
        take_rom_s    = 1'b0;
        bubble_s      = 1'b0;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        case (state_r)
            FS_BOOT: begin
                state_nxt_s = FS_FETCH;
            end
            FS_FETCH: begin
                if (rom.rom_rdy) begin
                    // The word is accepted even under stall; it parks in the skid slot
                    adv_s = 1'b1;
                    if (stall) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = FS_HOLD;
                    end else begin
                        take_rom_s = 1'b1;
                    end
                end else begin
                    bubble_s = !stall;
                end
            end
            FS_HOLD: begin
                if (stall) begin
                    state_nxt_s = FS_HOLD;
                end else begin
                    skid_unload_s = 1'b1;
                    state_nxt_s   = FS_FETCH;
                end
            end
            default: begin
                state_nxt_s = FS_BOOT;
            end
        endcase
    end

    // Next fetch address: fresh redirect, then parked redirect, then sequential
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (branch_flag) begin
            next_pc_s = align_pc(branch_addr);
        end else if (pend_vld_r) begin
            next_pc_s = align_pc(pend_addr_r);
        end else begin
            next_pc_s = align_pc(pc_r + 32'd4);
        end
    end

    // State register and registered request strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FS_BOOT;
            rom_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rom_en_r <= (state_nxt_s == FS_FETCH);
        end
    end

    // PC register and pending-redirect register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            pend_vld_r  <= 1'b0;
            pend_addr_r <= 32'd0;
        end else if (adv_s) begin
            pc_r       <= next_pc_s;
            pend_vld_r <= 1'b0;
        end else if (branch_flag) begin
            // Newest redirect wins if one is already parked
            pend_vld_r  <= 1'b1;
            pend_addr_r <= branch_addr;
        end
    end

    // IF/ID output register: fresh ROM word, skid replay, or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'd0;
            if_inst_r  <= 32'd0;
        end else if (take_rom_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= pc_r;
            if_inst_r  <= rom.rom_rdata;
        end else if (skid_unload_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= skid_data_s.pc;
            if_inst_r  <= skid_data_s.inst;
        end else if (bubble_s) begin
            if_valid_r <= 1'b0;
        end
    end

    assign skid_in_s = {pc_r, rom.rom_rdata};

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load_s),
        .din    (skid_in_s),
        .unload (skid_unload_s),
        .valid  (skid_valid_s),
        .data   (skid_data_s)
    );

    fetch_stage_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .branch_flag (branch_flag),
        .pend_vld    (pend_vld_r),
        .rom_en      (rom_en_r),
        .rom_rdy     (rom.rom_rdy),
        .rom_addr    (pc_r),
        .skid_unload (skid_unload_s),
        .skid_valid  (skid_valid_s)
    );

    assign rom.rom_en   = rom_en_r;
    assign rom.rom_addr = pc_r;
    assign if_valid     = if_valid_r;
    assign if_pc        = if_pc_r;
    assign if_inst      = if_inst_r;

endmodule
